mix_columns_row_sequencer: RTL and testbench

//  Time-multiplexes one shared GaloisOneRow instance over the four matrix rows to produce a full
//  128-bit (Inv)MixColumns result in 4 compute cycles, instead of four parallel row instances.

---
 rtl/mix_columns_row_sequencer_pkg.sv | 24 ++
 rtl/mix_columns_row_sequencer_if.sv | 22 ++
 rtl/GaloisOneRow.sv | 31 +++
 rtl/mix_columns_row_sequencer.sv | 84 ++++++++
 tb/tb_mix_columns_row_sequencer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mix_columns_row_sequencer_pkg.sv
// Shared constants, state encoding and row-rotation helper for the
// time-multiplexed (Inv)MixColumns sequencer.
package mix_columns_row_sequencer_pkg;

    localparam logic [31:0] MC_FWD_ROW0 = 32'h02030101;
    localparam logic [31:0] MC_INV_ROW0 = 32'h0e0b0d09;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Row r of the circulant matrix is row 0 rotated right by r bytes.
    function automatic logic [31:0] rot_row(input logic [31:0] row, input logic [1:0] idx);
        case (idx)
            2'd0:    return row;
            2'd1:    return {row[7:0],  row[31:8]};
            2'd2:    return {row[15:0], row[31:16]};
            default: return {row[23:0], row[31:24]};
        endcase
    endfunction

endpackage

// File: rtl/mix_columns_row_sequencer_if.sv
// Valid/ready bus for the MixColumns row sequencer: input state, result and control.
interface mix_columns_row_sequencer_if;
    logic         abort;
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    modport master (
        output abort, in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  abort, in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/GaloisOneRow.sv
// One matrix row times the 4x4 state: out byte c = sum_k row[k] * state[col c][byte k]
// over GF(2^8) with polynomial 0x11b. Purely combinational.
module GaloisOneRow (
    input  logic [31:0]  in_row,
    input  logic [127:0] in_data,
    output logic [31:0]  out_row
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    always_comb begin
        out_row = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                out_row[31-8*c -: 8] = out_row[31-8*c -: 8]
                    ^ gf_mul(in_row[31-8*k -: 8], in_data[127-32*c-8*k -: 8]);
            end
        end
    end

endmodule

// File: rtl/mix_columns_row_sequencer.sv
// Full-state (Inv)MixColumns using one shared row multiplier over four CALC cycles,
// scattering each row result into the matching byte of every output column.
module mix_columns_row_sequencer
    import mix_columns_row_sequencer_pkg::*;
#(
    parameter logic [31:0] INV_ROW0 = MC_INV_ROW0,
    parameter logic [31:0] FWD_ROW0 = MC_FWD_ROW0
) (
    input logic                          clk,
    input logic                          rst,
    mix_columns_row_sequencer_if.slave   bus
);

    state_t       state, state_nxt;
    logic [1:0]   row_cnt;
    logic         mode_q;
    logic [127:0] data_q;
    logic [127:0] out_q, out_nxt;
    logic [31:0]  sel_row;
    logic [31:0]  out_row;
    logic         accept;

    assign accept = (state == ST_IDLE) && bus.in_valid && !bus.abort;

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.busy      = (state == ST_CALC) || (state == ST_DONE);
    assign bus.out_data  = out_q;

    assign sel_row = rot_row(mode_q ? INV_ROW0 : FWD_ROW0, row_cnt);

    GaloisOneRow u_row (
        .in_row  (sel_row),
        .in_data (data_q),
        .out_row (out_row)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // abort wins over both the input accept and the output handshake.
    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (bus.in_valid)       state_nxt = ST_CALC;
                ST_CALC: if (row_cnt == 2'd3)    state_nxt = ST_DONE;
                ST_DONE: if (bus.out_ready)      state_nxt = ST_IDLE;
                default:                         state_nxt = ST_IDLE;
            endcase
        end
    end

    // Row row_cnt of the result lands at byte row_cnt of each column.
    always_comb begin
        out_nxt = out_q;
        for (int c = 0; c < 4; c++) begin
            out_nxt[127-32*c-8*int'(row_cnt) -: 8] = out_row[31-8*c -: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt <= 2'd0;
            mode_q  <= 1'b0;
            data_q  <= '0;
            out_q   <= '0;
        end else if (bus.abort) begin
            row_cnt <= 2'd0;
        end else if (accept) begin
            data_q  <= bus.in_data;
            mode_q  <= bus.in_mode;
            row_cnt <= 2'd0;
        end else if (state == ST_CALC) begin
            out_q   <= out_nxt;
            row_cnt <= row_cnt + 2'd1;
        end
    end

endmodule

// File: tb/tb_mix_columns_row_sequencer.sv
// Directed bench for mix_columns_row_sequencer using known AES MixColumns column vectors.
module tb_mix_columns_row_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mix_columns_row_sequencer_if bus ();

    mix_columns_row_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] V_A   = {4{32'h8e4da1bc}};
    localparam logic [127:0] V_AI  = {4{32'hdb135345}};
    localparam logic [127:0] V_B   = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] V_BF  = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] V_C   = {4{32'hc6c6c6c6}};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts edges after the accept edge until out_valid, bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic send(input logic mode, input logic [127:0] data);
        bus.in_valid = 1'b1;
        bus.in_mode  = mode;
        bus.in_data  = data;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    logic [127:0] vec_in  [3];
    logic         vec_md  [3];
    logic [127:0] vec_exp [3];
    int           acc_cyc [3];

    initial begin
        int lat;
        int ai, ri;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.abort = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_mode = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        repeat (2) tick();
        chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_out_data", bus.out_data, '0);
        rst = 1'b0;
        tick();

        // 1: reset after two CALC rows
        send(1'b1, V_A);
        chk("t1_busy", 128'(bus.busy), 128'd1);
        chk("t1_in_ready_calc", 128'(bus.in_ready), 128'd0);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        chk("t1_out_valid", 128'(bus.out_valid), 128'd0);
        chk("t1_in_ready", 128'(bus.in_ready), 128'd1);
        chk("t1_out_data", bus.out_data, '0);
        chk("t1_busy_after", 128'(bus.busy), 128'd0);
        rst = 1'b0;
        tick();

        // 2: inverse mode
        send(1'b1, V_A);
        wait_valid(lat);
        chk("t2_latency", 128'(lat), 128'd4);
        chk("t2_out_data", bus.out_data, V_AI);
        drain();
        chk("t2_in_ready", 128'(bus.in_ready), 128'd1);
        chk("t2_out_valid", 128'(bus.out_valid), 128'd0);

        // 3: forward mode
        send(1'b0, V_B);
        wait_valid(lat);
        chk("t3_latency", 128'(lat), 128'd4);
        chk("t3_out_data", bus.out_data, V_BF);

        // 4: backpressure while inputs wiggle
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.in_data  = {4{$urandom()}};
            bus.in_mode  = i[1];
            tick();
            chk("t4_hold_data", bus.out_data, V_BF);
            chk("t4_hold_in_ready", 128'(bus.in_ready), 128'd0);
        end
        bus.in_valid = 1'b0;
        drain();
        chk("t4_release_in_ready", 128'(bus.in_ready), 128'd1);

        // 5: abort on CALC row 1 with in_valid high
        send(1'b1, V_A);
        tick();
        bus.abort = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = V_B;
        tick();
        chk("t5_abort_in_ready", 128'(bus.in_ready), 128'd1);
        chk("t5_abort_busy", 128'(bus.busy), 128'd0);
        chk("t5_abort_out_valid", 128'(bus.out_valid), 128'd0);
        // abort in IDLE blocks the accept
        tick();
        chk("t5_idle_abort_busy", 128'(bus.busy), 128'd0);
        bus.abort = 1'b0;
        send(1'b1, V_C);
        wait_valid(lat);
        chk("t5_latency", 128'(lat), 128'd4);
        chk("t5_out_data", bus.out_data, V_C);
        // abort beats the output handshake; result register is kept
        bus.abort = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.out_ready = 1'b0;
        chk("t5_abort_done_valid", 128'(bus.out_valid), 128'd0);
        chk("t5_abort_keeps_data", bus.out_data, V_C);

        // 6: back-to-back streaming
        vec_in[0] = V_B;  vec_md[0] = 1'b0; vec_exp[0] = V_BF;
        vec_in[1] = V_A;  vec_md[1] = 1'b1; vec_exp[1] = V_AI;
        vec_in[2] = V_BF; vec_md[2] = 1'b1; vec_exp[2] = V_B;
        ai = 0;
        ri = 0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus.out_valid) begin
                if (ri < 3) chk("t6_result", bus.out_data, vec_exp[ri]);
                ri++;
            end
            if (bus.in_ready) begin
                if (ai < 3) begin
                    bus.in_valid = 1'b1;
                    bus.in_mode  = vec_md[ai];
                    bus.in_data  = vec_in[ai];
                    acc_cyc[ai]  = cyc;
                    ai++;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("t6_accepts", 128'(ai), 128'd3);
        chk("t6_results", 128'(ri), 128'd3);
        // IDLE(1) + CALC(4) + DONE(1) cycles between accepts
        chk("t6_period_01", 128'(acc_cyc[1] - acc_cyc[0]), 128'd6);
        chk("t6_period_12", 128'(acc_cyc[2] - acc_cyc[1]), 128'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
